// File: rtl/sbox_mul_pipe_reg.sv
// Two-entry skid buffer between the S-box multiplier layer (K outputs) and the
// bottom linear layer: valid/ready on both sides, sideband tag, sync flush.
module sbox_mul_pipe_reg #(
  parameter int unsigned K_WIDTH   = 4,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [K_WIDTH-1:0]   in_k,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [K_WIDTH-1:0]   out_k,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [1:0]           occupancy
);

  localparam int unsigned DW = K_WIDTH + TAG_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [1:0]      r_occupancy;
  logic [DW-1:0]   r_main;
  logic [DW-1:0]   r_skid;
  logic            w_in_xfer;
  logic            w_out_xfer;
  logic            w_ld_main_in;
  logic            w_ld_main_skid;
  logic            w_ld_skid;
  logic [1:0]      w_occ_nxt;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  // State register; occupancy, out_valid and in_ready are decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occupancy <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_occupancy <= w_occ_nxt;
    end
  end

  // Next-state logic; flush overrides any handshake in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_xfer) w_state_nxt = ST_ONE;
        ST_ONE: begin
          if (w_in_xfer && !w_out_xfer)      w_state_nxt = ST_FULL;
          else if (!w_in_xfer && w_out_xfer) w_state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (w_out_xfer) w_state_nxt = ST_ONE;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Datapath load controls and occupancy decode
  always_comb begin
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (!flush) begin
      case (r_state)
        ST_EMPTY: w_ld_main_in = w_in_xfer;
        ST_ONE: begin
          w_ld_main_in = w_in_xfer & w_out_xfer;
          w_ld_skid    = w_in_xfer & ~w_out_xfer;
        end
        ST_FULL:  w_ld_main_skid = w_out_xfer;
        default:  ;
      endcase
    end
    case (w_state_nxt)
      ST_ONE:  w_occ_nxt = 2'd1;
      ST_FULL: w_occ_nxt = 2'd2;
      default: w_occ_nxt = 2'd0;
    endcase
  end

  // Main and skid data registers; flush leaves stale contents behind out_valid=0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_in)        r_main <= {in_tag, in_k};
      else if (w_ld_main_skid) r_main <= r_skid;
      if (w_ld_skid)           r_skid <= {in_tag, in_k};
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign occupancy = r_occupancy;
  assign out_k     = r_main[K_WIDTH-1:0];
  assign out_tag   = r_main[DW-1:K_WIDTH];

endmodule
